// File: rtl/extmem_pkg.sv
// Shared definitions for the external-memory word interface: region base
// addresses, pixel width and the DMA master state encoding.
package extmem_pkg;

    localparam logic [31:0] OFS_INF_CONV = 32'h0000_0000;
    localparam logic [31:0] OFS_FMI      = 32'h0020_0000;
    localparam logic [31:0] OFS_FMO      = 32'h0040_0000;
    localparam logic [31:0] OFS_KEX      = 32'h0060_0000;
    localparam logic [31:0] OFS_KPW      = 32'h01A0_0000;
    localparam logic [31:0] OFS_KDW      = 32'h02C0_0000;

    localparam int unsigned PX_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        WR_STREAM = 3'd3,
        DONE      = 3'd4
    } dma_state_t;

endpackage

// File: rtl/extmem_dma_master.sv
// Block-transfer DMA master between the external word memory and one local RAM port.
// Loads issue one read at a time with a timeout; stores stream one word per cycle.
module extmem_dma_master
    import extmem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LADDR_W = 12,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [31:0]        cmd_ext_addr,
    input  logic [LADDR_W-1:0] cmd_loc_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               request_extmem,
    output logic               write_extmem,
    output logic [31:0]        addr_extmem,
    output logic [31:0]        w_data,
    input  logic               valid_extmem,
    input  logic [31:0]        data_extmem,
    output logic               loc_wr_en,
    output logic [LADDR_W-1:0] loc_wr_addr,
    output logic [DATA_W-1:0]  loc_wr_data,
    output logic               loc_rd_en,
    output logic [LADDR_W-1:0] loc_rd_addr,
    input  logic [DATA_W-1:0]  loc_rd_data,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    dma_state_t         state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [31:0]        ext_addr_q, ext_addr_d;
    logic [LADDR_W-1:0] loc_addr_q, loc_addr_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               req_q, req_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic               lwe_q, lwe_d;
    logic [LADDR_W-1:0] lwa_q, lwa_d;
    logic [DATA_W-1:0]  lwd_q, lwd_d;
    logic               lre_q, lre_d;
    logic [LADDR_W-1:0] lra_q, lra_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               unused_data_hi;

    assign accept         = cmd_valid && cmd_ready_q && (state_q == IDLE);
    assign unused_data_hi = ^data_extmem[31:DATA_W];

    // Next-state, counter and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        ext_addr_d  = ext_addr_q;
        loc_addr_d  = loc_addr_q;
        req_d       = 1'b0;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        lwe_d       = 1'b0;
        lwa_d       = lwa_q;
        lwd_d       = lwd_q;
        lre_d       = 1'b0;
        lra_d       = lra_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d    = WR_STREAM;
                        lre_d      = 1'b1;
                        lra_d      = cmd_loc_addr;
                        loc_addr_d = cmd_loc_addr + LADDR_W'(1);
                        cnt_d      = cmd_len - LEN_W'(1);
                        ext_addr_d = cmd_ext_addr;
                    end else begin
                        state_d    = RD_REQ;
                        req_d      = 1'b1;
                        addr_d     = cmd_ext_addr;
                        ext_addr_d = cmd_ext_addr + 32'd1;
                        loc_addr_d = cmd_loc_addr;
                        cnt_d      = cmd_len;
                    end
                end
            end
            RD_REQ: begin
                // The request cycle itself counts toward the timeout
                state_d = RD_WAIT;
                tcnt_d  = TO_W'(1);
            end
            RD_WAIT: begin
                if (valid_extmem) begin
                    lwe_d      = 1'b1;
                    lwa_d      = loc_addr_q;
                    lwd_d      = data_extmem[DATA_W-1:0];
                    loc_addr_d = loc_addr_q + LADDR_W'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RD_REQ;
                        req_d      = 1'b1;
                        addr_d     = ext_addr_q;
                        ext_addr_d = ext_addr_q + 32'd1;
                    end
                end else if (tcnt_q >= TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            WR_STREAM: begin
                // Each local read issued last cycle becomes an external write now
                if (lre_q) begin
                    wr_d       = 1'b1;
                    addr_d     = ext_addr_q;
                    ext_addr_d = ext_addr_q + 32'd1;
                end else begin
                    state_d = DONE;
                end
                if (cnt_q != '0) begin
                    lre_d      = 1'b1;
                    lra_d      = loc_addr_q;
                    loc_addr_d = loc_addr_q + LADDR_W'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            ext_addr_q  <= '0;
            loc_addr_q  <= '0;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            lwe_q       <= 1'b0;
            lwa_q       <= '0;
            lwd_q       <= '0;
            lre_q       <= 1'b0;
            lra_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            ext_addr_q  <= ext_addr_d;
            loc_addr_q  <= loc_addr_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            lwe_q       <= lwe_d;
            lwa_q       <= lwa_d;
            lwd_q       <= lwd_d;
            lre_q       <= lre_d;
            lra_q       <= lra_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign request_extmem = req_q;
    assign write_extmem   = wr_q;
    assign addr_extmem    = addr_q;
    // Local RAM data lands one cycle after the read, so it is forwarded straight out
    assign w_data         = wr_q ? 32'(loc_rd_data) : 32'd0;
    assign loc_wr_en      = lwe_q;
    assign loc_wr_addr    = lwa_q;
    assign loc_wr_data    = lwd_q;
    assign loc_rd_en      = lre_q;
    assign loc_rd_addr    = lra_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_extmem_dma_master.sv
// Directed bench for extmem_dma_master: loads, stores, zero length, timeout,
// mid-transfer reset and back-to-back commands with local address wrap.
module tb_extmem_dma_master;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned LADDR_W = 12;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid, cmd_ready, cmd_write;
    logic [31:0]        cmd_ext_addr;
    logic [LADDR_W-1:0] cmd_loc_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic               request_extmem, write_extmem;
    logic [31:0]        addr_extmem, w_data;
    logic               valid_extmem;
    logic [31:0]        data_extmem;
    logic               loc_wr_en, loc_rd_en;
    logic [LADDR_W-1:0] loc_wr_addr, loc_rd_addr;
    logic [DATA_W-1:0]  loc_wr_data, loc_rd_data;
    logic               busy, done, err_timeout;

    int total = 0;
    int bad   = 0;

    extmem_dma_master #(
        .DATA_W(DATA_W), .LADDR_W(LADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_ext_addr(cmd_ext_addr), .cmd_loc_addr(cmd_loc_addr), .cmd_len(cmd_len),
        .request_extmem(request_extmem), .write_extmem(write_extmem),
        .addr_extmem(addr_extmem), .w_data(w_data),
        .valid_extmem(valid_extmem), .data_extmem(data_extmem),
        .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
        .loc_rd_en(loc_rd_en), .loc_rd_addr(loc_rd_addr), .loc_rd_data(loc_rd_data),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Two-cycle-latency responder; returned word = 0xBEEF in the top half, addr+0xA below
    logic [1:0]  sh = 2'b00;
    logic [31:0] a1 = '0, a2 = '0;
    logic        resp_en = 1'b1;
    logic        man_valid = 1'b0;
    always @(posedge clk) begin
        sh <= {sh[0], request_extmem};
        a1 <= addr_extmem;
        a2 <= a1;
    end
    assign valid_extmem = (sh[1] & resp_en) | man_valid;
    assign data_extmem  = {16'hBEEF, a2[15:0] + 16'h000A};

    logic [DATA_W-1:0] rd_mem [0:4095];
    logic [DATA_W-1:0] wr_mem [0:4095];
    int req_n = 0, wr_n = 0, lwr_n = 0, lrd_n = 0, done_n = 0, both_n = 0;
    always @(posedge clk) begin
        if (loc_rd_en) loc_rd_data <= rd_mem[loc_rd_addr];
        if (loc_wr_en) wr_mem[loc_wr_addr] <= loc_wr_data;
        if (request_extmem) req_n <= req_n + 1;
        if (write_extmem) wr_n <= wr_n + 1;
        if (loc_wr_en) lwr_n <= lwr_n + 1;
        if (loc_rd_en) lrd_n <= lrd_n + 1;
        if (done) done_n <= done_n + 1;
        if (request_extmem && write_extmem) both_n <= both_n + 1;
    end

    logic [31:0] req_q[$], ra_q[$], wrc_q[$], wa_q[$], wd_q[$], rdc_q[$];
    int err_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick();
        end
        if (!cmd_ready) chk("wait_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic accept(input logic w, input logic [31:0] ext, input logic [LADDR_W-1:0] loc,
                          input logic [LEN_W-1:0] len);
        wait_ready();
        cmd_write    = w;
        cmd_ext_addr = ext;
        cmd_loc_addr = loc;
        cmd_len      = len;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    // Sample cycles T1.. after an accept until done; cycle numbers relative to accept
    task automatic run_xfer(input int limit, output int done_c);
        done_c = -1;
        err_c  = -1;
        req_q.delete(); ra_q.delete(); wrc_q.delete(); wa_q.delete(); wd_q.delete(); rdc_q.delete();
        for (int c = 1; c <= limit; c++) begin
            if (request_extmem) begin req_q.push_back(32'(c)); ra_q.push_back(addr_extmem); end
            if (write_extmem) begin
                wrc_q.push_back(32'(c)); wa_q.push_back(addr_extmem); wd_q.push_back(w_data);
            end
            if (loc_rd_en) rdc_q.push_back(32'(c));
            if (err_timeout && err_c < 0) err_c = c;
            if (done) begin done_c = c; break; end
            tick();
        end
    endtask

    int dc, b_req, b_wr, b_lwr, b_lrd, b_done;
    logic low_flag;

    task automatic snap();
        b_req = req_n; b_wr = wr_n; b_lwr = lwr_n; b_lrd = lrd_n; b_done = done_n;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_ext_addr = '0; cmd_loc_addr = '0; cmd_len = '0;
        rd_mem[5] = 16'h1111; rd_mem[6] = 16'h2222; rd_mem[7] = 16'h3333;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_request", 32'(request_extmem), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;

        // Load 4 words from FMI base
        snap();
        accept(1'b0, 32'h0020_0000, 12'h000, 16'd4);
        chk("ld_busy_t1", 32'(busy), 32'd1);
        run_xfer(60, dc);
        tick();
        chk("ld_done_cycle", 32'(dc), 32'd13);
        chk("ld_req_count", 32'(req_q.size()), 32'd4);
        chk("ld_req0", qget(req_q, 0), 32'd1);
        chk("ld_req1", qget(req_q, 1), 32'd4);
        chk("ld_req2", qget(req_q, 2), 32'd7);
        chk("ld_req3", qget(req_q, 3), 32'd10);
        chk("ld_addr0", qget(ra_q, 0), 32'h0020_0000);
        chk("ld_addr3", qget(ra_q, 3), 32'h0020_0003);
        chk("ld_mem0", 32'(wr_mem[0]), 32'h000A);
        chk("ld_mem1", 32'(wr_mem[1]), 32'h000B);
        chk("ld_mem2", 32'(wr_mem[2]), 32'h000C);
        chk("ld_mem3", 32'(wr_mem[3]), 32'h000D);
        chk("ld_lwr_n", 32'(lwr_n - b_lwr), 32'd4);
        chk("ld_done_n", 32'(done_n - b_done), 32'd1);
        chk("ld_err", 32'(err_timeout), 32'd0);

        // Store 3 words from local 5..7 to FMO base
        snap();
        accept(1'b1, 32'h0040_0000, 12'h005, 16'd3);
        run_xfer(30, dc);
        tick();
        chk("st_done_cycle", 32'(dc), 32'd5);
        chk("st_rd0", qget(rdc_q, 0), 32'd1);
        chk("st_rd2", qget(rdc_q, 2), 32'd3);
        chk("st_rd_count", 32'(rdc_q.size()), 32'd3);
        chk("st_wr_count", 32'(wrc_q.size()), 32'd3);
        chk("st_wr0", qget(wrc_q, 0), 32'd2);
        chk("st_wr1", qget(wrc_q, 1), 32'd3);
        chk("st_wr2", qget(wrc_q, 2), 32'd4);
        chk("st_wa0", qget(wa_q, 0), 32'h0040_0000);
        chk("st_wa1", qget(wa_q, 1), 32'h0040_0001);
        chk("st_wa2", qget(wa_q, 2), 32'h0040_0002);
        chk("st_wd0", qget(wd_q, 0), 32'h0000_1111);
        chk("st_wd1", qget(wd_q, 1), 32'h0000_2222);
        chk("st_wd2", qget(wd_q, 2), 32'h0000_3333);
        chk("st_req_n", 32'(req_n - b_req), 32'd0);

        // Zero-length command
        snap();
        accept(1'b0, 32'h0060_0000, 12'h100, 16'd0);
        chk("z_busy_t1", 32'(busy), 32'd1);
        run_xfer(10, dc);
        tick();
        chk("z_done_cycle", 32'(dc), 32'd1);
        chk("z_req_n", 32'(req_n - b_req), 32'd0);
        chk("z_wr_n", 32'(wr_n - b_wr), 32'd0);
        chk("z_loc_n", 32'((lwr_n - b_lwr) + (lrd_n - b_lrd)), 32'd0);

        // Silent responder -> timeout abort
        snap();
        resp_en = 1'b0;
        accept(1'b0, 32'h0020_0040, 12'h050, 16'd2);
        run_xfer(60, dc);
        tick();
        resp_en = 1'b1;
        chk("to_done_cycle", 32'(dc), 32'd17);
        chk("to_err_cycle", 32'(err_c), 32'd17);
        chk("to_req_n", 32'(req_n - b_req), 32'd1);
        chk("to_lwr_n", 32'(lwr_n - b_lwr), 32'd0);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        accept(1'b0, 32'h0, 12'h000, 16'd0);
        chk("to_err_clear", 32'(err_timeout), 32'd0);
        run_xfer(10, dc);
        tick();

        // Reset in RD_WAIT after 2 of 4 words
        snap();
        accept(1'b0, 32'h0020_0010, 12'h020, 16'd4);
        repeat (7) tick();
        chk("rs_lwr_before", 32'(lwr_n - b_lwr), 32'd2);
        chk("rs_mem21", 32'(wr_mem[12'h021]), 32'h001B);
        rst = 1'b1;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_request", 32'(request_extmem), 32'd0);
        chk("rs_addr", addr_extmem, 32'd0);
        chk("rs_loc_wr", {loc_wr_en, 7'd0, loc_rd_en, 7'd0, 4'd0, loc_wr_addr}, 32'd0);
        chk("rs_ready_done_err", {29'd0, cmd_ready, done, err_timeout}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        tick();
        tick();
        chk("rs_late_valid", 32'(lwr_n - b_lwr), 32'd2);
        accept(1'b0, 32'h0020_0020, 12'h030, 16'd2);
        run_xfer(30, dc);
        tick();
        chk("rs_fresh_done", 32'(dc), 32'd7);
        chk("rs_fresh_mem0", 32'(wr_mem[12'h030]), 32'h002A);
        chk("rs_fresh_mem1", 32'(wr_mem[12'h031]), 32'h002B);

        // Held second command with local wrap on the first
        wait_ready();
        cmd_write = 1'b0; cmd_ext_addr = 32'h0020_0100; cmd_loc_addr = 12'hFFE; cmd_len = 16'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_ext_addr = 32'h0020_0200; cmd_loc_addr = 12'h010; cmd_len = 16'd1;
        low_flag = 1'b1;
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (cmd_ready) low_flag = 1'b0;
            if (done) begin dc = c; break; end
            tick();
        end
        chk("hold_done_cycle", 32'(dc), 32'd10);
        chk("hold_ready_low", 32'(low_flag), 32'd1);
        tick();
        chk("hold_ready_after", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("hold_second_req", 32'(request_extmem), 32'd1);
        chk("hold_second_addr", addr_extmem, 32'h0020_0200);
        run_xfer(30, dc);
        tick();
        chk("hold_second_done", 32'(dc), 32'd4);
        chk("wrap_mem_ffe", 32'(wr_mem[12'hFFE]), 32'h010A);
        chk("wrap_mem_fff", 32'(wr_mem[12'hFFF]), 32'h010B);
        chk("wrap_mem_000", 32'(wr_mem[12'h000]), 32'h010C);
        chk("second_mem_010", 32'(wr_mem[12'h010]), 32'h020A);
        chk("req_wr_overlap", 32'(both_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
